// File: rtl/key_pkg.sv
// key_pkg -- shared definitions for the key_debounce front end.
//   State encoding for the per-channel debounce FSM, plus helpers that turn
//   millisecond settings into clock-cycle counts and size counters to fit them.
//   No ports (package).
package key_pkg;

   localparam logic [1:0] ST_IDLE_C         = 2'd0;
   localparam logic [1:0] ST_PRESS_WAIT_C   = 2'd1;
   localparam logic [1:0] ST_HELD_C         = 2'd2;
   localparam logic [1:0] ST_RELEASE_WAIT_C = 2'd3;

   typedef enum logic [1:0] {
      IDLE         = ST_IDLE_C,
      PRESS_WAIT   = ST_PRESS_WAIT_C,
      HELD         = ST_HELD_C,
      RELEASE_WAIT = ST_RELEASE_WAIT_C
   } key_state_e;

   function automatic int ms_to_cycles(input int clk_hz, input int ms);
      return (clk_hz / 1000) * ms;
   endfunction

   // Bits needed to hold values 0..max_val (never less than one bit).
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch -- one push-button channel.
//   Synchronises an active-low pin, debounces it with a timed counter and
//   produces a clean level, press/release pulses, a toggle LED and, when
//   KEY_LONG_PRESS_EN is defined, a one-shot long-press pulse.
// Ports:
//   clk          system clock
//   rst_n        synchronous reset, active low
//   key_pin      raw pin, 0 = pressed
//   key_level    debounced level, 1 = pressed
//   key_press    1-cycle pulse on accepted press
//   key_release  1-cycle pulse on accepted release
//   led          toggles on every accepted press
//   long_press   1-cycle pulse once per hold of LONG_MAX+1 cycles (0 without macro)
//
// state        | meaning
// IDLE         | level 0, synced input released
// PRESS_WAIT   | level 0, input pressed, counting towards acceptance
// HELD         | level 1, synced input pressed
// RELEASE_WAIT | level 1, input released, counting towards acceptance
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int CNT_MAX     = 4,
   parameter int LONG_MAX    = 19,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_pin,
   output logic key_level,
   output logic key_press,
   output logic key_release,
   output logic led,
   output logic long_press
);

   localparam int CW = cnt_width(CNT_MAX);
   localparam logic [CW-1:0] CNT_MAX_C = CW'(CNT_MAX);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   key_state_e             state_q, state_d;
   logic                   level_q, level_d;
   logic                   press_q, press_d;
   logic                   release_q, release_d;
   logic                   led_q, led_d;
   logic                   s;
   logic                   done;

   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], key_pin};
      s         = ~sync_q[SYNC_STAGES-1];
      // Counter only runs while the synced input disagrees with the accepted level.
      done      = (s != level_q) && (cnt_q == CNT_MAX_C);
      cnt_d     = ((s == level_q) || done) ? '0 : cnt_q + CW'(1);
      state_d   = state_q;
      case (state_q)
         IDLE:         if (s) state_d = PRESS_WAIT;
         PRESS_WAIT:   if (!s) state_d = IDLE;
                       else if (done) state_d = HELD;
         HELD:         if (!s) state_d = RELEASE_WAIT;
         RELEASE_WAIT: if (s) state_d = HELD;
                       else if (done) state_d = IDLE;
         default:      state_d = IDLE;
      endcase
      level_d   = (state_d == HELD) || (state_d == RELEASE_WAIT);
      press_d   = (state_q == PRESS_WAIT) && (state_d == HELD);
      release_d = (state_q == RELEASE_WAIT) && (state_d == IDLE);
      led_d     = led_q ^ press_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q    <= '1;
         cnt_q     <= '0;
         state_q   <= IDLE;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         led_q     <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         led_q     <= led_d;
      end
   end

   assign key_level   = level_q;
   assign key_press   = press_q;
   assign key_release = release_q;
   assign led         = led_q;

`ifdef KEY_LONG_PRESS_EN
   // One extra code (LONG_MAX+1) marks "already fired" so the pulse is one-shot.
   localparam int HW = cnt_width(LONG_MAX + 1);
   localparam logic [HW-1:0] LONG_MAX_C = HW'(LONG_MAX);
   localparam logic [HW-1:0] LONG_SAT_C = HW'(LONG_MAX + 1);

   logic [HW-1:0] hold_q, hold_d;
   logic          long_q, long_d;

   always_comb begin
      hold_d = '0;
      long_d = 1'b0;
      if (state_q == HELD) begin
         if (hold_q == LONG_MAX_C) begin
            long_d = 1'b1;
            hold_d = LONG_SAT_C;
         end else if (hold_q == LONG_SAT_C) begin
            hold_d = hold_q;
         end else begin
            hold_d = hold_q + HW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_d;
      end
   end

   assign long_press = long_q;
`else
   assign long_press = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// key_debounce -- N-channel push-button front end.
//   Instantiates KEY_NUM independent debounce channels.
//   Optional macro: KEY_LONG_PRESS_EN enables the per-key long_press pulse.
// Ports:
//   clk          system clock
//   rst_n        synchronous reset, active low
//   key          raw key pins, 0 = pressed
//   key_level    debounced level, 1 = pressed
//   key_press    1-cycle pulse on accepted press
//   key_release  1-cycle pulse on accepted release
//   led          per-key toggle, flips on each press
//   long_press   1-cycle pulse once per long hold (0 without KEY_LONG_PRESS_EN)
module key_debounce
   import key_pkg::*;
#(
   parameter int KEY_NUM     = 4,
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int DEBOUNCE_MS = 20,
   parameter int SYNC_STAGES = 2,
   parameter int LONG_MS     = 1000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [KEY_NUM-1:0] key,
   output logic [KEY_NUM-1:0] key_level,
   output logic [KEY_NUM-1:0] key_press,
   output logic [KEY_NUM-1:0] key_release,
   output logic [KEY_NUM-1:0] led,
   output logic [KEY_NUM-1:0] long_press
);

   localparam int CNT_MAX  = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS) - 1;
   localparam int LONG_MAX = ms_to_cycles(CLK_FREQ_HZ, LONG_MS) - 1;

   for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
      key_debounce_ch #(
         .CNT_MAX     (CNT_MAX),
         .LONG_MAX    (LONG_MAX),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .key_pin     (key[i]),
         .key_level   (key_level[i]),
         .key_press   (key_press[i]),
         .key_release (key_release[i]),
         .led         (led[i]),
         .long_press  (long_press[i])
      );
   end

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;

   logic       clk;
   logic       rst_n;
   logic [3:0] key;
   logic [3:0] key_level, key_press, key_release, led, long_press;

   int total = 0;
   int bad   = 0;

   key_debounce #(
      .KEY_NUM     (4),
      .CLK_FREQ_HZ (1000),
      .DEBOUNCE_MS (5),
      .SYNC_STAGES (2),
      .LONG_MS     (20)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key         (key),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release),
      .led         (led),
      .long_press  (long_press)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       rst_n;
      logic [3:0] key;
      int         n;      // cycles to hold inputs; full check after the last one
      logic [3:0] lvl;
      logic [3:0] prs;
      logic [3:0] rel;
      logic [3:0] led;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic [3:0] k, input int n,
                      input logic [3:0] lv, input logic [3:0] p,
                      input logic [3:0] rl, input logic [3:0] ld);
      vec_t v;
      v.rst_n = r; v.key = k; v.n = n;
      v.lvl = lv; v.prs = p; v.rel = rl; v.led = ld;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%b exp=%b t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   int press_cyc, long_cyc, long_cnt, stray;

   initial begin
      rst_n = 1'b0;
      key   = 4'b1111;

      // reset with all keys held, then release: all four pressed together at edge 7
      add(0, 4'b0000, 2, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(1, 4'b0000, 6, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(1, 4'b0000, 1, 4'b1111, 4'b1111, 4'b0000, 4'b1111);
      add(1, 4'b0000, 1, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
      // reset while keys are released: clean slate
      add(0, 4'b1111, 2, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(1, 4'b1111, 8, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      // clean press / release of key 0
      add(1, 4'b1110, 6, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(1, 4'b1110, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
      add(1, 4'b1110, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
      add(1, 4'b1111, 6, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
      add(1, 4'b1111, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
      add(1, 4'b1111, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      // bounce on key 1: never stable long enough
      add(1, 4'b1101, 3, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      add(1, 4'b1111, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      add(1, 4'b1101, 3, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      add(1, 4'b1111, 8, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      // keys 3 and 2 together, then key 2 again
      add(1, 4'b0011, 6, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      add(1, 4'b0011, 1, 4'b1100, 4'b1100, 4'b0000, 4'b1101);
      add(1, 4'b0011, 1, 4'b1100, 4'b0000, 4'b0000, 4'b1101);
      add(1, 4'b1111, 6, 4'b1100, 4'b0000, 4'b0000, 4'b1101);
      add(1, 4'b1111, 1, 4'b0000, 4'b0000, 4'b1100, 4'b1101);
      add(1, 4'b1111, 1, 4'b0000, 4'b0000, 4'b0000, 4'b1101);
      add(1, 4'b1011, 6, 4'b0000, 4'b0000, 4'b0000, 4'b1101);
      add(1, 4'b1011, 1, 4'b0100, 4'b0100, 4'b0000, 4'b1001);
      add(1, 4'b1011, 1, 4'b0100, 4'b0000, 4'b0000, 4'b1001);
      add(1, 4'b1111, 6, 4'b0100, 4'b0000, 4'b0000, 4'b1001);
      add(1, 4'b1111, 1, 4'b0000, 4'b0000, 4'b0100, 4'b1001);
      add(1, 4'b1111, 1, 4'b0000, 4'b0000, 4'b0000, 4'b1001);
      // reset in the middle of a key 0 debounce, press re-detected afterwards
      add(1, 4'b1110, 3, 4'b0000, 4'b0000, 4'b0000, 4'b1001);
      add(0, 4'b1110, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(1, 4'b1110, 6, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(1, 4'b1110, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
      add(1, 4'b1110, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
      // release bounce while held: level must stay pressed
      add(1, 4'b1111, 3, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
      add(1, 4'b1110, 6, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
      add(1, 4'b1111, 6, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
      add(1, 4'b1111, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
      add(1, 4'b1111, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0001);

      for (int v = 0; v < vecs.size(); v++) begin
         rst_n = vecs[v].rst_n;
         key   = vecs[v].key;
         for (int c = 1; c <= vecs[v].n; c++) begin
            @(posedge clk);
            #1;
            if (c < vecs[v].n) begin
               chk($sformatf("v%0d_c%0d_no_press", v, c), key_press, 4'b0000);
               chk($sformatf("v%0d_c%0d_no_release", v, c), key_release, 4'b0000);
            end
         end
         chk($sformatf("v%0d_level", v), key_level, vecs[v].lvl);
         chk($sformatf("v%0d_press", v), key_press, vecs[v].prs);
         chk($sformatf("v%0d_release", v), key_release, vecs[v].rel);
         chk($sformatf("v%0d_led", v), led, vecs[v].led);
      end

      // long hold on key 0
      key       = 4'b1110;
      press_cyc = -1;
      long_cyc  = -1;
      long_cnt  = 0;
      stray     = 0;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk);
         #1;
         if (key_press[0] && press_cyc < 0) press_cyc = c;
         if (long_press[0]) begin
            long_cnt++;
            long_cyc = c;
         end
         if (long_press[3:1] != 3'b000) stray++;
      end
      chk_int("hold_press_cycle", press_cyc, 7);
`ifdef KEY_LONG_PRESS_EN
      chk_int("long_press_count", long_cnt, 1);
      chk_int("long_press_cycle", long_cyc, 27);
`else
      chk_int("long_press_count", long_cnt, 0);
`endif
      chk_int("long_press_other_keys", stray, 0);
      chk("hold_level", key_level, 4'b0001);

      key = 4'b1111;
      repeat (8) @(posedge clk);
      #1;
      chk("final_level", key_level, 4'b0000);
      chk("final_led", led, 4'b0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
